// File: rtl/lfsr_run_ctrl_if.sv
// Bundle of board-request, datapath and status signals for lfsr_run_ctrl.
//   master : board/datapath side; drives seed, requests and lfsr_q feedback.
//   slave  : controller side; drives lfsr_ld/lfsr_en/lfsr_seed and status outputs.
interface lfsr_run_ctrl_if;
    logic [7:0] seed;
    logic       load_req;
    logic       run_req;
    logic       step_req;
    logic [7:0] lfsr_q;
    logic       lfsr_ld;
    logic       lfsr_en;
    logic [7:0] lfsr_seed;
    logic       busy;
    logic       seed_err;
    logic [7:0] period;
    logic       period_vld;

    modport master (
        output seed, load_req, run_req, step_req, lfsr_q,
        input  lfsr_ld, lfsr_en, lfsr_seed, busy, seed_err, period, period_vld
    );

    modport slave (
        input  seed, load_req, run_req, step_req, lfsr_q,
        output lfsr_ld, lfsr_en, lfsr_seed, busy, seed_err, period, period_vld
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Sequencer for the 8-bit LFSR datapath behind the two-digit hex display.
// Loads a seed (rejecting the all-zero lock-up value), free-runs the LFSR at one
// step per DIV clocks or single-steps it while paused, and measures the sequence
// period by counting steps until the state returns to the seed.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - lfsr_run_ctrl_if.slave: seed/load_req/run_req/step_req/lfsr_q in;
//          lfsr_ld/lfsr_en/lfsr_seed/busy/seed_err/period/period_vld out
//
// Optional build macro LFSR_RUN_CTRL_AUTOSTOP_EN: leave RUN as soon as a period is
// captured; RUN is re-entered only after run_req is seen low then high again.
module lfsr_run_ctrl #(
    parameter int unsigned DIV   = 25000000,
    parameter int unsigned DIV_W = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_run_ctrl_if.slave       bus
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StStep, StErr} state_e;

    localparam logic [DIV_W-1:0] PrescMax = DIV_W'(DIV - 1);

    state_e           state_q, state_d;
    logic             lfsr_ld_q, lfsr_ld_d;
    logic             lfsr_en_q, lfsr_en_d;
    logic [7:0]       lfsr_seed_q, lfsr_seed_d;
    logic             busy_q, busy_d;
    logic             seed_err_q, seed_err_d;
    logic [7:0]       period_q, period_d;
    logic             period_vld_q, period_vld_d;
    logic             loaded_q, loaded_d;
    logic [7:0]       step_cnt_q, step_cnt_d;
    logic             sat_q, sat_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             chk_q, chk_d;
    logic             capture;
    logic             run_ok;

`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
    // Set on auto-stop; blocks RUN until run_req has been seen low.
    logic run_hold_q, run_hold_d;
    assign run_ok = bus.run_req && loaded_q && !run_hold_q;
`else
    assign run_ok = bus.run_req && loaded_q;
`endif

    // chk_q marks the cycle after a step, when lfsr_q already shows the new state.
    // sat_q blocks capture once the step count has overflowed its 8-bit range.
    assign capture = chk_q && (bus.lfsr_q == lfsr_seed_q) && !period_vld_q && !sat_q;

    always_comb begin
        state_d      = state_q;
        lfsr_ld_d    = 1'b0;
        lfsr_en_d    = 1'b0;
        lfsr_seed_d  = lfsr_seed_q;
        period_d     = period_q;
        period_vld_d = period_vld_q;
        loaded_d     = loaded_q;
        step_cnt_d   = step_cnt_q;
        sat_d        = sat_q;
        presc_d      = presc_q;
        chk_d        = 1'b0;
`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
        run_hold_d   = run_hold_q;
        if (!bus.run_req) begin
            run_hold_d = 1'b0;
        end
`endif

        // Count the step the datapath takes on this edge.
        if (lfsr_en_q) begin
            chk_d = 1'b1;
            if (step_cnt_q == 8'hFF) begin
                sat_d = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 8'd1;
            end
        end

        if (capture) begin
            period_d     = step_cnt_q;
            period_vld_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (run_ok) begin
                    state_d = StRun;
                end else if (bus.step_req && loaded_q) begin
                    state_d   = StStep;
                    lfsr_en_d = 1'b1;
                end
            end
            StLoad: begin
                state_d = bus.run_req ? StRun : StIdle;
            end
            StStep: begin
                state_d = StIdle;
            end
            StRun: begin
                if (!bus.run_req) begin
                    state_d = StIdle;
                    presc_d = '0;
`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
                end else if (capture) begin
                    state_d    = StIdle;
                    presc_d    = '0;
                    run_hold_d = 1'b1;
`endif
                end else if (presc_q == PrescMax) begin
                    presc_d   = '0;
                    lfsr_en_d = 1'b1;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            StErr: begin
                // Held until a nonzero seed is loaded.
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Load overrides everything else in every state.
        if (bus.load_req) begin
            lfsr_en_d    = 1'b0;
            period_vld_d = 1'b0;
            chk_d        = 1'b0;
            if (bus.seed == 8'h00) begin
                state_d  = StErr;
                loaded_d = 1'b0;
            end else begin
                state_d     = StLoad;
                lfsr_ld_d   = 1'b1;
                lfsr_seed_d = bus.seed;
                step_cnt_d  = 8'h00;
                sat_d       = 1'b0;
                period_d    = 8'h00;
                presc_d     = '0;
                loaded_d    = 1'b1;
`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
                run_hold_d  = 1'b0;
`endif
            end
        end

        busy_d     = (state_d == StRun);
        seed_err_d = (state_d == StErr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            lfsr_ld_q    <= 1'b0;
            lfsr_en_q    <= 1'b0;
            lfsr_seed_q  <= 8'h00;
            busy_q       <= 1'b0;
            seed_err_q   <= 1'b0;
            period_q     <= 8'h00;
            period_vld_q <= 1'b0;
            loaded_q     <= 1'b0;
            step_cnt_q   <= 8'h00;
            sat_q        <= 1'b0;
            presc_q      <= '0;
            chk_q        <= 1'b0;
`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
            run_hold_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_ld_q    <= lfsr_ld_d;
            lfsr_en_q    <= lfsr_en_d;
            lfsr_seed_q  <= lfsr_seed_d;
            busy_q       <= busy_d;
            seed_err_q   <= seed_err_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            loaded_q     <= loaded_d;
            step_cnt_q   <= step_cnt_d;
            sat_q        <= sat_d;
            presc_q      <= presc_d;
            chk_q        <= chk_d;
`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
            run_hold_q   <= run_hold_d;
`endif
        end
    end

    assign bus.lfsr_ld    = lfsr_ld_q;
    assign bus.lfsr_en    = lfsr_en_q;
    assign bus.lfsr_seed  = lfsr_seed_q;
    assign bus.busy       = busy_q;
    assign bus.seed_err   = seed_err_q;
    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Self-checking bench for lfsr_run_ctrl with a behavioural maximal-length LFSR
// datapath (x^8+x^4+x^3+x^2+1, Galois form) closing the lfsr_q feedback loop.
module tb_lfsr_run_ctrl;

    localparam int unsigned Div = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    lfsr_run_ctrl_if bus();

    lfsr_run_ctrl #(.DIV(Div), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], 1'b0} ^ (q[7] ? 8'h1D : 8'h00);
    endfunction

    // Datapath model: load has priority over step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.lfsr_q <= 8'h00;
        end else if (bus.lfsr_ld) begin
            bus.lfsr_q <= bus.lfsr_seed;
        end else if (bus.lfsr_en) begin
            bus.lfsr_q <= lfsr_next(bus.lfsr_q);
        end
    end

    typedef struct {
        logic       ld;
        logic       run;
        logic       step;
        logic [7:0] seed;
        logic       e_ld;
        logic       e_en;
        logic       e_busy;
        logic       e_err;
        logic [7:0] e_seed;
        logic       e_vld;
    } vec_t;

    function automatic vec_t v(input logic ld, input logic run, input logic step,
                               input logic [7:0] seed, input logic e_ld, input logic e_en,
                               input logic e_busy, input logic e_err,
                               input logic [7:0] e_seed, input logic e_vld);
        vec_t r;
        r.ld = ld; r.run = run; r.step = step; r.seed = seed;
        r.e_ld = e_ld; r.e_en = e_en; r.e_busy = e_busy; r.e_err = e_err;
        r.e_seed = e_seed; r.e_vld = e_vld;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic run, input logic step,
                         input logic [7:0] seed);
        bus.load_req = ld;
        bus.run_req  = run;
        bus.step_req = step;
        bus.seed     = seed;
    endtask

    vec_t vecs[$];
    int   en_cnt;
    bit   got;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst lfsr_ld", 32'(bus.lfsr_ld), 32'd0);
        check("rst lfsr_en", 32'(bus.lfsr_en), 32'd0);
        check("rst lfsr_seed", 32'(bus.lfsr_seed), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst seed_err", 32'(bus.seed_err), 32'd0);
        check("rst period", 32'(bus.period), 32'd0);
        check("rst period_vld", 32'(bus.period_vld), 32'd0);
        rst = 1'b1;

        //                  ld run stp seed   eld een ebsy eerr eseed evld
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0)); // step, not loaded
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0)); // run, not loaded
        vecs.push_back(v(1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0)); // zero seed rejected
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 1, 8'h00, 0)); // step in ERR
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0)); // run in ERR
        vecs.push_back(v(1, 0, 0, 8'h01, 1, 0, 0, 0, 8'h01, 0)); // good load
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h01, 0)); // step 1
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h01, 0)); // step during STEP
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h01, 0)); // step 2
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h01, 0)); // step 3
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h01, 0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0)); // enter RUN
        vecs.push_back(v(0, 1, 1, 8'h00, 0, 0, 1, 0, 8'h01, 0)); // step in RUN ignored
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 1, 1, 0, 8'h01, 0)); // DIV-th cycle
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0));
        vecs.push_back(v(1, 1, 0, 8'hA5, 1, 0, 0, 0, 8'hA5, 0)); // reload mid-run
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0)); // LOAD -> RUN
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 0));
        vecs.push_back(v(0, 1, 0, 8'h00, 0, 1, 1, 0, 8'hA5, 0));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0)); // pause
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].run, vecs[i].step, vecs[i].seed);
            tick();
            check($sformatf("row%0d lfsr_ld", i), 32'(bus.lfsr_ld), 32'(vecs[i].e_ld));
            check($sformatf("row%0d lfsr_en", i), 32'(bus.lfsr_en), 32'(vecs[i].e_en));
            check($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            check($sformatf("row%0d seed_err", i), 32'(bus.seed_err), 32'(vecs[i].e_err));
            check($sformatf("row%0d lfsr_seed", i), 32'(bus.lfsr_seed), 32'(vecs[i].e_seed));
            check($sformatf("row%0d period_vld", i), 32'(bus.period_vld), 32'(vecs[i].e_vld));
        end

        // Run cadence: one step every DIV cycles, none once paused.
        drive(1'b1, 1'b1, 1'b0, 8'h01);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        en_cnt = 0;
        repeat (41) begin
            tick();
            if (bus.lfsr_en) en_cnt++;
        end
        check("run pulses", 32'(en_cnt), 32'd10);
        check("run busy", 32'(bus.busy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        en_cnt = 0;
        repeat (20) begin
            tick();
            if (bus.lfsr_en) en_cnt++;
        end
        check("paused pulses", 32'(en_cnt), 32'd0);
        check("paused busy", 32'(bus.busy), 32'd0);

        // Period capture from seed 0x01 on the maximal-length datapath.
        drive(1'b1, 1'b1, 1'b0, 8'h01);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        got = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (bus.period_vld) begin
                got = 1'b1;
                break;
            end
        end
        check("period_vld timeout", 32'(got), 32'd1);
        check("period value", 32'(bus.period), 32'hFF);
        check("lfsr back at seed", 32'(bus.lfsr_q), 32'h01);
`ifdef LFSR_RUN_CTRL_AUTOSTOP_EN
        check("autostop busy", 32'(bus.busy), 32'd0);
        en_cnt = 0;
        repeat (20) begin
            tick();
            if (bus.lfsr_en) en_cnt++;
        end
        check("autostop pulses", 32'(en_cnt), 32'd0);
        check("autostop held", 32'(bus.busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("autostop rerun busy", 32'(bus.busy), 32'd1);
`else
        check("capture busy", 32'(bus.busy), 32'd1);
        repeat (1100) tick();
        check("period held vld", 32'(bus.period_vld), 32'd1);
        check("period held value", 32'(bus.period), 32'hFF);
        check("still running", 32'(bus.busy), 32'd1);
`endif

        // Asynchronous reset in the middle of a run.
        drive(1'b1, 1'b1, 1'b0, 8'h5A);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        repeat (6) tick();
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("async busy", 32'(bus.busy), 32'd0);
        check("async lfsr_seed", 32'(bus.lfsr_seed), 32'd0);
        check("async period", 32'(bus.period), 32'd0);
        check("async period_vld", 32'(bus.period_vld), 32'd0);
        check("async seed_err", 32'(bus.seed_err), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check("post-reset step", 32'(bus.lfsr_en), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check("post-reset run", 32'(bus.busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
